// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_mp
//  Purpose  : Multi-port register file with asynchronous reads, synchronous
//             writes and a sequential clear engine. Register 0 reads as zero.
//             After reset, or on clr_req, the array is zeroed one entry per
//             cycle. ready is low until the clear completes.
//  Ports    : cpu_clk_50M - single clock, rising edge
//             cpu_rst     - synchronous active-high reset
//             clr_req     - one-cycle request to re-zero the array (RUN only)
//             ready       - high while the array is usable (state RUN)
//             rd_en/rd_addr/rd_data - NUM_RD packed read ports
//             wr_en/wr_addr/wr_data - NUM_WR packed write ports
//  Options  : REGFILE_MP_BYPASS_EN - when defined, a read of an address being
//             written in the same cycle returns the write data.
//  Revision : 1.0 - initial release
// ============================================================================
module regfile_mp #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 32,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 2
) (
    input  logic                        cpu_clk_50M,
    input  logic                        cpu_rst,
    input  logic                        clr_req,
    output logic                        ready,
    input  logic [NUM_RD-1:0]           rd_en,
    input  logic [NUM_RD*$clog2(DEPTH)-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0]    rd_data,
    input  logic [NUM_WR-1:0]           wr_en,
    input  logic [NUM_WR*$clog2(DEPTH)-1:0] wr_addr,
    input  logic [NUM_WR*DATA_W-1:0]    wr_data
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [0:0]    c_ST_CLEAR = 1'b0;
    localparam logic [0:0]    c_ST_RUN   = 1'b1;
    localparam logic [AW-1:0] c_LAST_IDX = AW'(DEPTH - 1);
    localparam logic [AW-1:0] c_ZERO_IDX = '0;

    logic [0:0]        r_state;
    logic [0:0]        w_state_nxt;
    logic [AW-1:0]     r_clr_idx;
    logic [AW-1:0]     w_clr_idx_nxt;
    logic              w_clr_we;
    logic [NUM_WR-1:0] w_wr_act;

    logic [DATA_W-1:0] r_mem [DEPTH];

    logic [AW-1:0]     w_wr_addr [NUM_WR];
    logic [DATA_W-1:0] w_wr_data [NUM_WR];

    // ------------------------------------------------------------------
    // Unpack write ports
    // ------------------------------------------------------------------
    generate
        for (genvar g = 0; g < NUM_WR; g++) begin : g_wr_unpack
            assign w_wr_addr[g] = wr_addr[g*AW +: AW];
            assign w_wr_data[g] = wr_data[g*DATA_W +: DATA_W];
        end
    endgenerate

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge cpu_clk_50M) begin
        if (cpu_rst) begin
            r_state   <= c_ST_CLEAR;
            r_clr_idx <= c_ZERO_IDX;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_idx <= w_clr_idx_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_clr_idx_nxt = r_clr_idx;
        case (r_state)
            c_ST_CLEAR: begin
                w_clr_idx_nxt = r_clr_idx + AW'(1);
                if (r_clr_idx == c_LAST_IDX) begin
                    w_state_nxt = c_ST_RUN;
                end
            end
            c_ST_RUN: begin
                if (clr_req) begin
                    w_state_nxt   = c_ST_CLEAR;
                    w_clr_idx_nxt = c_ZERO_IDX;
                end
            end
            default: begin
                w_state_nxt   = c_ST_CLEAR;
                w_clr_idx_nxt = c_ZERO_IDX;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs. A write is committed only in RUN, outside reset, when
    // no clear is being requested, and to a nonzero address.
    // ------------------------------------------------------------------
    always_comb begin
        ready    = (r_state == c_ST_RUN);
        w_clr_we = (r_state == c_ST_CLEAR);
        for (int w = 0; w < NUM_WR; w++) begin
            w_wr_act[w] = (r_state == c_ST_RUN) && !cpu_rst && !clr_req &&
                          wr_en[w] && (w_wr_addr[w] != c_ZERO_IDX);
        end
    end

    // ------------------------------------------------------------------
    // Storage. Ascending port order makes the highest-index port win on
    // an address collision.
    // ------------------------------------------------------------------
    always_ff @(posedge cpu_clk_50M) begin
        if (w_clr_we && !cpu_rst) begin
            r_mem[r_clr_idx] <= '0;
        end else begin
            for (int w = 0; w < NUM_WR; w++) begin
                if (w_wr_act[w]) begin
                    r_mem[w_wr_addr[w]] <= w_wr_data[w];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Asynchronous read ports
    // ------------------------------------------------------------------
    generate
        for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
            logic [AW-1:0]     w_addr;
            logic [DATA_W-1:0] w_val;

            always_comb begin
                w_addr = rd_addr[i*AW +: AW];
                w_val  = r_mem[w_addr];
`ifdef REGFILE_MP_BYPASS_EN
                // Forward only writes that will actually commit this edge.
                for (int w = 0; w < NUM_WR; w++) begin
                    if (w_wr_act[w] && (w_wr_addr[w] == w_addr)) begin
                        w_val = w_wr_data[w];
                    end
                end
`else
                w_val = w_val;
`endif
                if (!rd_en[i] || (w_addr == c_ZERO_IDX) || !ready || cpu_rst) begin
                    w_val = '0;
                end
            end

            assign rd_data[i*DATA_W +: DATA_W] = w_val;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// ============================================================================
//  Module   : tb_regfile_mp
//  Purpose  : Scoreboard testbench for regfile_mp (default parameters).
//             Stimulus pushes expected read data; a negedge monitor pops and
//             compares for every port marked for checking in that cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_mp;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 2;
    localparam int NW = 2;

`ifdef REGFILE_MP_BYPASS_EN
    localparam logic [31:0] c_BYP = 32'hCAFEF00D;
`else
    localparam logic [31:0] c_BYP = 32'h00000000;
`endif

    logic              cpu_clk_50M;
    logic              cpu_rst;
    logic              clr_req;
    logic              ready;
    logic [NR-1:0]     rd_en;
    logic [NR*AW-1:0]  rd_addr;
    logic [NR*DW-1:0]  rd_data;
    logic [NW-1:0]     wr_en;
    logic [NW*AW-1:0]  wr_addr;
    logic [NW*DW-1:0]  wr_data;

    logic [NR-1:0]     chk_mask;

    typedef struct {
        string       nm;
        logic [31:0] exp;
    } exp_t;

    exp_t sb_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    regfile_mp #(
        .DATA_W (DW),
        .DEPTH  (32),
        .NUM_RD (NR),
        .NUM_WR (NW)
    ) dut (
        .cpu_clk_50M (cpu_clk_50M),
        .cpu_rst     (cpu_rst),
        .clr_req     (clr_req),
        .ready       (ready),
        .rd_en       (rd_en),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data)
    );

    initial cpu_clk_50M = 1'b0;
    always #10 cpu_clk_50M = ~cpu_clk_50M;

    // Monitor: compare read data for each port flagged this cycle
    always @(negedge cpu_clk_50M) begin
        exp_t e;
        for (int p = 0; p < NR; p++) begin
            if (chk_mask[p]) begin
                n_chk++;
                if (sb_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_underflow port %0d got %h required a queued entry",
                             p, rd_data[p*DW +: DW]);
                end else begin
                    e = sb_q.pop_front();
                    if (rd_data[p*DW +: DW] !== e.exp) begin
                        n_fail++;
                        $display("FAIL %s port %0d got %h required %h",
                                 e.nm, p, rd_data[p*DW +: DW], e.exp);
                    end
                end
            end
        end
    end

    task automatic check(input string nm, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got %0d required %0d", nm, got, exp);
        end
    endtask

    task automatic idle();
        rd_en    = '0;
        wr_en    = '0;
        clr_req  = 1'b0;
        chk_mask = '0;
    endtask

    task automatic tick();
        @(posedge cpu_clk_50M);
        #1;
        idle();
    endtask

    task automatic rd(input int p, input logic [AW-1:0] a, input logic [31:0] e,
                      input string nm);
        exp_t x;
        rd_en[p]             = 1'b1;
        rd_addr[p*AW +: AW]  = a;
        chk_mask[p]          = 1'b1;
        x.nm  = nm;
        x.exp = e;
        sb_q.push_back(x);
    endtask

    task automatic rd_off(input int p, input logic [AW-1:0] a, input string nm);
        exp_t x;
        rd_en[p]             = 1'b0;
        rd_addr[p*AW +: AW]  = a;
        chk_mask[p]          = 1'b1;
        x.nm  = nm;
        x.exp = 32'h0;
        sb_q.push_back(x);
    endtask

    task automatic wr(input int p, input logic [AW-1:0] a, input logic [31:0] d);
        wr_en[p]             = 1'b1;
        wr_addr[p*AW +: AW]  = a;
        wr_data[p*DW +: DW]  = d;
    endtask

    // Count rising edges until ready is seen high (bounded). With hold set,
    // clr_req and a write to addr 2 are kept asserted while clearing.
    task automatic wait_ready(input bit hold, input string nm);
        int n;
        n = 0;
        while (n < 100) begin
            @(posedge cpu_clk_50M);
            #1;
            n++;
            idle();
            if (ready) break;
            if (hold) begin
                clr_req = 1'b1;
                wr(0, 5'd2, 32'h55555555);
            end
        end
        check(nm, n, 32);
    endtask

    task automatic read_all_zero(input string nm);
        for (int k = 0; k < 16; k++) begin
            rd(0, 5'(2*k), 32'h0, nm);
            rd(1, 5'(2*k+1), 32'h0, nm);
            tick();
        end
    endtask

    function automatic logic [31:0] fill_val(input int a);
        return (a == 0) ? 32'h0 : (32'hA0000000 | 32'(a));
    endfunction

    initial begin
        cpu_rst = 1'b1;
        rd_addr = '0;
        wr_addr = '0;
        wr_data = '0;
        idle();

        // Reset and initial clear
        repeat (3) @(posedge cpu_clk_50M);
        #1;
        check("ready_in_reset", int'(ready), 0);
        cpu_rst = 1'b0;
        wait_ready(1'b0, "ready_latency_por");
        read_all_zero("por_zero");

        // Basic write/read, address 0 write ignored
        wr(0, 5'd5, 32'hDEADBEEF);
        wr(1, 5'd0, 32'h12345678);
        tick();
        rd(0, 5'd0, 32'h0, "addr0_reads_zero");
        rd(1, 5'd5, 32'hDEADBEEF, "rd_p1_addr5");
        tick();

        // Write collision: highest port wins
        wr(0, 5'd7, 32'h11111111);
        wr(1, 5'd7, 32'h22222222);
        tick();
        rd(0, 5'd7, 32'h22222222, "collision_p0");
        rd(1, 5'd7, 32'h22222222, "collision_p1");
        tick();

        // Same-cycle write/read, then following cycle
        wr(0, 5'd3, 32'hCAFEF00D);
        rd(1, 5'd3, c_BYP, "same_cycle_rd3");
        tick();
        rd(0, 5'd3, 32'hCAFEF00D, "next_cycle_rd3_p0");
        rd(1, 5'd3, 32'hCAFEF00D, "next_cycle_rd3_p1");
        tick();

        // Disabled read port outputs zero
        rd_off(0, 5'd5, "rd_en_low");
        rd(1, 5'd5, 32'hDEADBEEF, "rd_en_high");
        tick();

        // Fill registers 1..31
        for (int a = 1; a < 32; a += 2) begin
            wr(0, 5'(a), fill_val(a));
            if (a + 1 < 32) wr(1, 5'(a + 1), fill_val(a + 1));
            tick();
        end
        for (int k = 0; k < 16; k++) begin
            rd(0, 5'(2*k), fill_val(2*k), "fill_rd");
            rd(1, 5'(2*k+1), fill_val(2*k+1), "fill_rd");
            tick();
        end

        // Clear request with a concurrent write that must be dropped
        clr_req = 1'b1;
        wr(0, 5'd9, 32'hBAD0BAD0);
        rd(1, 5'd9, 32'hA0000009, "rd9_at_clr");
        tick();
        check("ready_after_clr", int'(ready), 0);
        clr_req = 1'b1;
        wr(0, 5'd2, 32'h55555555);
        wait_ready(1'b1, "ready_latency_clr");
        read_all_zero("clr_zero");

        // Reset during clear at index 10 restarts clearing
        wr(0, 5'd20, 32'h00001234);
        wr(1, 5'd25, 32'h00005678);
        tick();
        clr_req = 1'b1;
        tick();
        repeat (10) tick();
        check("ready_mid_clear", int'(ready), 0);
        cpu_rst = 1'b1;
        rd(0, 5'd20, 32'h0, "rd_mid_clear");
        tick();
        check("ready_after_rst", int'(ready), 0);
        cpu_rst = 1'b0;
        wait_ready(1'b0, "ready_latency_rst_restart");
        read_all_zero("rst_restart_zero");

        // Reset gates read data even while RUN
        wr(0, 5'd6, 32'h66666666);
        tick();
        rd(0, 5'd6, 32'h66666666, "rd6_run");
        tick();
        cpu_rst = 1'b1;
        rd(0, 5'd6, 32'h0, "rd_during_rst");
        rd(1, 5'd5, 32'h0, "rd_during_rst");
        tick();
        cpu_rst = 1'b0;
        tick();

        check("sb_queue_empty", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog got timeout required completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register width in bits.
REQ-002 SHALL have parameter DEPTH, default 32, number of registers (power of two, >= 4); AW = clog2(DEPTH).
REQ-003 SHALL have parameter NUM_RD, default 2, number of read ports (1..4).
REQ-004 SHALL have parameter NUM_WR, default 2, number of write ports (1..2).
REQ-005 SHALL have port cpu_clk_50M  input  1  single clock; all state changes on rising edge.
REQ-006 SHALL have port cpu_rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port clr_req  input  1  one-cycle request to re-zero the whole array.
REQ-008 SHALL have port ready  output  1  array usable; low while clearing.
REQ-009 SHALL have port rd_en  input  NUM_RD  per-port read enable.
REQ-010 SHALL have port rd_addr  input  NUM_RD*AW  packed read addresses; port i at bits [i*AW +: AW].
REQ-011 SHALL have port rd_data  output  NUM_RD*DATA_W  packed read data; port i at bits [i*DATA_W +: DATA_W].
REQ-012 SHALL have port wr_en  input  NUM_WR  per-port write enable.
REQ-013 SHALL have port wr_addr  input  NUM_WR*AW  packed write addresses.
REQ-014 SHALL have port wr_data  input  NUM_WR*DATA_W  packed write data.

Function
REQ-015 SHALL implement a two-state FSM: CLEAR and RUN, with an AW-bit clear index clr_idx.
REQ-016 In CLEAR, SHALL write zero to register clr_idx each cycle and increment clr_idx; on clr_idx == DEPTH-1, SHALL go to RUN next edge.
REQ-017 In RUN, clr_req = 1 SHALL move to CLEAR with clr_idx = 0 on the next edge; enabled writes in that cycle SHALL be discarded.
REQ-018 In CLEAR, clr_req SHALL be ignored and wr_en SHALL be ignored.
REQ-019 ready SHALL be 1 exactly when state is RUN (registered, no combinational path from inputs).
REQ-020 In RUN, each write port with wr_en = 1 and wr_addr != 0 SHALL update that register on the rising edge; write latency one cycle.
REQ-021 Register 0 SHALL always read as zero; writes to address 0 SHALL have no effect.
REQ-022 Two write ports to the same nonzero address in one cycle: port NUM_WR-1 (highest index) SHALL win.
REQ-023 Reads SHALL be asynchronous (combinational from rd_addr and array).
REQ-024 rd_data of port i SHALL be zero when rd_en[i] = 0, rd_addr = 0, ready = 0, or cpu_rst = 1.
REQ-025 Multiple read ports SHALL be independent; identical addresses on all ports are legal.

Reset
REQ-026 cpu_rst = 1 at a rising edge SHALL force state CLEAR, clr_idx = 0, ready = 0; array contents are then cleared by the FSM, not by reset.
REQ-027 Reset asserted mid-CLEAR SHALL restart clearing from index 0.
REQ-028 After cpu_rst falls, ready SHALL rise after exactly DEPTH rising edges with cpu_rst low, and all registers SHALL read zero.

Configuration
REQ-029 Macro REGFILE_MP_BYPASS_EN defined: in RUN, a read whose address matches an enabled same-cycle write (nonzero address) SHALL return that write's wr_data; highest-index write port wins; rules of REQ-024 still apply.
REQ-030 REGFILE_MP_BYPASS_EN undefined: reads SHALL return stored contents only; same-cycle write data visible the following cycle.

Verification
REQ-031 Reset then release, DEPTH=32 -> ready low 32 cycles then high; all 32 addresses read 0x00000000.
REQ-032 RUN: wr port0 addr 5 data 0xDEADBEEF -> next cycle rd port1 addr 5 returns 0xDEADBEEF; write addr 0 data 0x12345678 -> addr 0 reads 0.
REQ-033 Both write ports addr 7, port0 0x11111111, port1 0x22222222 -> addr 7 reads 0x22222222.
REQ-034 Same-cycle write addr 3 0xCAFEF00D and read addr 3 (old 0) -> reads 0xCAFEF00D with REGFILE_MP_BYPASS_EN, 0x00000000 without; both read 0xCAFEF00D next cycle.
REQ-035 Fill regs 1..31, pulse clr_req with concurrent write addr 9 -> write dropped, ready low 32 cycles, all reads 0 after.
REQ-036 Assert cpu_rst at clr_idx = 10 during CLEAR -> clearing restarts; ready rises 32 cycles after release.
